// File: rtl/tm_input_pkg.sv
// Shared types and defaults for the Turing-machine input conditioner.
// Load-session states plus the tape-count width helper.
package tm_input_pkg;

    typedef enum logic [0:0] {
        LOAD,
        FINISHED
    } ld_state_t;

    localparam int unsigned DEFAULT_DATA_W   = 6;
    localparam int unsigned DEFAULT_TAPE_LEN = 64;

    // One extra bit so the count can represent TAPE_LEN itself.
    function automatic int unsigned count_w(input int unsigned len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/tm_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and registered rising-edge pulse
// for one active-high push button.
module tm_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    // Counter clears whenever input and debounced level agree, so any glitch
    // shorter than DEBOUNCE_CYCLES leaves the level untouched.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/tm_input_conditioner.sv
// Front end of the Turing-machine core: synchronizes and debounces the Next/Done buttons,
// captures the symbol switches and issues single-cycle Next/Done strobes per load session.
module tm_input_conditioner
    import tm_input_pkg::*;
#(
    parameter int unsigned DATA_W          = DEFAULT_DATA_W,
    parameter int unsigned TAPE_LEN        = DEFAULT_TAPE_LEN,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         next_raw,
    input  logic                         done_raw,
    input  logic [DATA_W-1:0]            data_raw,
    output logic [DATA_W-1:0]            input_data,
    output logic                         Next,
    output logic                         Done,
    output logic [count_w(TAPE_LEN)-1:0] tape_count,
    output logic                         tape_full,
    output logic                         loading
);

    localparam int unsigned CNT_W = count_w(TAPE_LEN);

    logic              next_level, next_rise, done_level, done_rise;
    logic              next_event, done_event;
    logic [DATA_W-1:0] data_s1_q, data_s2_q;

    ld_state_t         state_q, state_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              next_q, next_d;
    logic              done_q, done_d;

    tm_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_db (
        .clock(clock),
        .reset(reset),
        .raw  (next_raw),
        .level(next_level),
        .rise (next_rise)
    );

    tm_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_done_db (
        .clock(clock),
        .reset(reset),
        .raw  (done_raw),
        .level(done_level),
        .rise (done_rise)
    );

    assign next_event = next_rise & next_level;
    assign done_event = done_rise & done_level;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        data_d    = data_q;
        next_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (done_q) begin
                    // Leave LOAD only after the Done strobe has been visible for a cycle.
                    state_d = FINISHED;
                end else if (pending_q) begin
                    done_d    = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    if (next_event && (count_q < CNT_W'(TAPE_LEN))) begin
                        next_d  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        data_d  = data_s2_q;
                    end
                    if (done_event) begin
                        if (next_d) begin
                            pending_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            FINISHED: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            state_q   <= LOAD;
            pending_q <= 1'b0;
            count_q   <= '0;
            data_q    <= '0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            data_s1_q <= data_raw;
            data_s2_q <= data_s1_q;
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            data_q    <= data_d;
            next_q    <= next_d;
            done_q    <= done_d;
        end
    end

    assign input_data = data_q;
    assign Next       = next_q;
    assign Done       = done_q;
    assign tape_count = count_q;
    assign tape_full  = (count_q == CNT_W'(TAPE_LEN));
    assign loading    = (state_q == LOAD);

endmodule

// File: doc/tm_input_conditioner.md
Name: tm_input_conditioner

Overview:
Front-end stage directly upstream of the Turing-machine core. Synchronizes the raw chip-pin button and switch inputs, debounces the Next and Done buttons, and emits clean single-cycle strobes with a stable 6-bit symbol. Tracks how many symbols have been loaded and blocks loading beyond tape capacity or after Done. Its outputs connect one-to-one to the core's input_data, Next and Done inputs.

Parameters:
DATA_W, 6, symbol width, matching the core's input_data width
TAPE_LEN, 64, maximum number of symbols accepted per load session
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a button level change; must be at least 1

Ports:
clock  input  1  single system clock
reset  input  1  synchronous, active-low; asserted when 0, sampled on rising clock
next_raw  input  1  asynchronous Next button, active-high
done_raw  input  1  asynchronous Done button, active-high
data_raw  input  DATA_W  asynchronous symbol switches
input_data  output  DATA_W  symbol captured with the most recent Next strobe
Next  output  1  one-cycle strobe, one per accepted Next press
Done  output  1  one-cycle strobe, emitted exactly once per session
tape_count  output  $clog2(TAPE_LEN)+1  number of Next strobes issued this session
tape_full  output  1  high when tape_count == TAPE_LEN
loading  output  1  high while in state LOAD

Behaviour:
- Reset (reset==0 at a rising edge): all synchronizer flops, debounce counters and debounced levels go to 0. input_data=0, Next=0, Done=0, tape_count=0, tape_full=0. State=LOAD, loading=1, done_pending=0.
- Synchronization: every raw input passes through a 2-flop synchronizer. Only synchronized values are used downstream.
- Debounce, per button:
  - Counter increments each cycle the synchronized level differs from the debounced level; it clears to 0 on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Edge detection: a press event is a 0->1 transition of the debounced level. Release (1->0) produces nothing.
- Latency: raw level held stable from rising edge k gives its strobe high in the cycle following edge k+2+DEBOUNCE_CYCLES.
- Data capture: on an accepted Next event, input_data <= synchronized data_raw sampled at that same edge. input_data holds until the next accepted Next event or reset.
- State LOAD:
  - Next event with tape_count < TAPE_LEN: Next=1 for one cycle, tape_count increments, data captured.
  - Next event with tape_count == TAPE_LEN: event dropped. No strobe, input_data unchanged, tape_full stays 1.
  - Done event alone: Done=1 for one cycle, then state -> FINISHED.
  - Next and Done events on the same cycle: Next is processed that cycle and done_pending is set. Done=1 on the following cycle, then state -> FINISHED. Next and Done are never high together.
  - Done with tape_count==0 is legal and emits Done normally.
- State FINISHED: loading=0. All button events are ignored and outputs are held. Leaving FINISHED requires reset.
- Reset mid-operation: reset clears everything, including a pending Done and partial debounce counts. A button held through reset is re-detected as a fresh press DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- tape_full is combinational from tape_count. Next and Done are registered outputs.

Decomposition:
- Package tm_input_pkg holds:
  - enum ld_state_t {LOAD, FINISHED}
  - default constants DATA_W=6, TAPE_LEN=64
  - count-width localparam function
- Sub-module tm_debounce, one per button, instantiated twice:
  - contains the 2-flop synchronizer, stability counter, debounced level and rising-edge pulse
  - parameter DEBOUNCE_CYCLES; ports clock, reset, raw, level, rise
- Data synchronizers and the FSM sit in the top module.

Test Plan (DEBOUNCE_CYCLES=4, TAPE_LEN=64):
1. data_raw=6'h2A, next_raw held high from edge k -> Next=1 only in the cycle after edge k+6, input_data=6'h2A, tape_count=1; holding longer gives no second strobe.
2. next_raw pulsed high for 3 cycles, low 2, high 3 (bouncing) -> no Next strobe; then held 10 cycles -> exactly one Next.
3. 64 clean Next presses with data_raw=i -> tape_count=64, tape_full=1, input_data=6'h3F; 65th press with data_raw=6'h01 -> no strobe, input_data stays 6'h3F.
4. next_raw and done_raw rise on the same edge, data_raw=6'h05 -> Next=1 in cycle c, Done=1 in cycle c+1, loading=0 from c+2; input_data=6'h05.
5. After Done, press Next and Done again -> no strobes, tape_count unchanged, loading=0.
6. Hold next_raw, assert reset=0 for 2 cycles after 3 stable cycles -> no strobe during or before reset; after release, Next appears 6 cycles later with tape_count=1.
